// File: rtl/column_l1route_seq_if.sv
// Request/response bundle between the column route sequencer, its request source and the QSN router side.
// shift_err_o exists only when SHIFT_RANGE_CHK_EN is defined.
interface column_l1route_seq_if #(
    parameter int BITWIDTH_SHIFT_FACTOR = 4,
    parameter int COL_ADDR_WIDTH        = 5
);
    logic                             req_valid_i;
    logic                             req_ready_o;
    logic                             req_src_i;
    logic [BITWIDTH_SHIFT_FACTOR-1:0] req_shift_i;
    logic [COL_ADDR_WIDTH-1:0]        req_col_i;
    logic                             req_last_i;

    logic [BITWIDTH_SHIFT_FACTOR-1:0] shift_factor_o;
    logic                             sw_in_src_o;
    logic                             launch_o;
    logic                             out_valid_o;
    logic [COL_ADDR_WIDTH-1:0]        out_col_o;
    logic                             out_src_o;
    logic                             out_last_o;
    logic                             done_o;
    logic                             busy_o;
    logic                             src_err_o;
`ifdef SHIFT_RANGE_CHK_EN
    logic                             shift_err_o;
`endif

    modport master (
        output req_valid_i, req_src_i, req_shift_i, req_col_i, req_last_i,
        input  req_ready_o, shift_factor_o, sw_in_src_o, launch_o,
        input  out_valid_o, out_col_o, out_src_o, out_last_o,
        input  done_o, busy_o, src_err_o
`ifdef SHIFT_RANGE_CHK_EN
        , input shift_err_o
`endif
    );

    modport slave (
        input  req_valid_i, req_src_i, req_shift_i, req_col_i, req_last_i,
        output req_ready_o, shift_factor_o, sw_in_src_o, launch_o,
        output out_valid_o, out_col_o, out_src_o, out_last_o,
        output done_o, busy_o, src_err_o
`ifdef SHIFT_RANGE_CHK_EN
        , output shift_err_o
`endif
    );
endinterface

// File: rtl/column_l1route_seq.sv
// Column L1 QSN router sequencer: launch at accept+1, out_valid at accept+1+QSN_LAT; ready low only while draining, no downstream backpressure.
// Optional SHIFT_RANGE_CHK_EN: out-of-range shifts are launched as 0 and flagged on sticky shift_err_o.
module column_l1route_seq #(
    parameter int STRIDE_UNIT_SIZE      = 15,
    parameter int BITWIDTH_SHIFT_FACTOR = $clog2(STRIDE_UNIT_SIZE-1),
    parameter int QSN_LAT               = 2,
    parameter int COL_ADDR_WIDTH        = 5
) (
    input  logic                 sys_clk,
    input  logic                 rstn,
    column_l1route_seq_if.slave  rt_if
);

    localparam int CNT_W = $clog2(QSN_LAT+1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    typedef struct packed {
        logic                      vld;
        logic [COL_ADDR_WIDTH-1:0] col;
        logic                      src;
        logic                      last;
    } tag_t;

    state_t                           r_state;
    state_t                           w_state_nxt;
    logic [CNT_W-1:0]                 r_cnt;
    logic [CNT_W-1:0]                 w_cnt_nxt;
    logic                             r_burst_src;
    logic                             w_burst_src_nxt;

    logic                             w_ready;
    logic                             w_accept;
    logic                             w_src_eff;
    logic                             w_src_bad;
    logic                             w_done;
    logic [BITWIDTH_SHIFT_FACTOR-1:0] w_shift_eff;

    logic [BITWIDTH_SHIFT_FACTOR-1:0] r_shift;
    tag_t                             r_launch_tag;
    tag_t                             r_tag_pipe [QSN_LAT];
    logic                             r_src_err;

    assign w_ready  = (r_state != ST_DRAIN);
    assign w_accept = rt_if.req_valid_i & w_ready;

    // Mid-burst beats follow the source latched at burst start, even if the request disagrees.
    assign w_src_eff = (r_state == ST_ACTIVE) ? r_burst_src : rt_if.req_src_i;
    assign w_src_bad = w_accept & (r_state == ST_ACTIVE) & (rt_if.req_src_i != r_burst_src);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_burst_src_nxt = r_burst_src;
        w_done          = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_burst_src_nxt = rt_if.req_src_i;
                    if (rt_if.req_last_i) begin
                        w_state_nxt = ST_DRAIN;
                        w_cnt_nxt   = CNT_W'(QSN_LAT);
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (w_accept && rt_if.req_last_i) begin
                    w_state_nxt = ST_DRAIN;
                    w_cnt_nxt   = CNT_W'(QSN_LAT);
                end
            end
            ST_DRAIN: begin
                // Counter reaches zero exactly when the last beat leaves the tag pipe.
                if (r_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_burst_src <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_burst_src <= w_burst_src_nxt;
        end
    end

`ifdef SHIFT_RANGE_CHK_EN
    localparam logic [BITWIDTH_SHIFT_FACTOR-1:0] SHIFT_MAX =
        BITWIDTH_SHIFT_FACTOR'(STRIDE_UNIT_SIZE-1);

    logic w_shift_bad;
    logic r_shift_err;

    assign w_shift_bad = (rt_if.req_shift_i > SHIFT_MAX);
    assign w_shift_eff = w_shift_bad ? '0 : rt_if.req_shift_i;

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_shift_err <= 1'b0;
        end else if (w_accept && w_shift_bad) begin
            r_shift_err <= 1'b1;
        end
    end

    assign rt_if.shift_err_o = r_shift_err;
`else
    assign w_shift_eff = rt_if.req_shift_i;
`endif

    // Router controls only move on a launch; otherwise they hold for the buffers.
    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_shift      <= '0;
            r_launch_tag <= '0;
        end else begin
            r_launch_tag.vld <= w_accept;
            if (w_accept) begin
                r_shift           <= w_shift_eff;
                r_launch_tag.col  <= rt_if.req_col_i;
                r_launch_tag.src  <= w_src_eff;
                r_launch_tag.last <= rt_if.req_last_i;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < QSN_LAT; i++) begin
                r_tag_pipe[i] <= '0;
            end
        end else begin
            r_tag_pipe[0] <= r_launch_tag;
            for (int i = 1; i < QSN_LAT; i++) begin
                r_tag_pipe[i] <= r_tag_pipe[i-1];
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rstn) begin
        if (!rstn) begin
            r_src_err <= 1'b0;
        end else if (w_src_bad) begin
            r_src_err <= 1'b1;
        end
    end

    assign rt_if.req_ready_o    = w_ready;
    assign rt_if.shift_factor_o = r_shift;
    assign rt_if.sw_in_src_o    = r_launch_tag.src;
    assign rt_if.launch_o       = r_launch_tag.vld;
    assign rt_if.out_valid_o    = r_tag_pipe[QSN_LAT-1].vld;
    assign rt_if.out_col_o      = r_tag_pipe[QSN_LAT-1].col;
    assign rt_if.out_src_o      = r_tag_pipe[QSN_LAT-1].src;
    assign rt_if.out_last_o     = r_tag_pipe[QSN_LAT-1].last;
    assign rt_if.done_o         = w_done;
    assign rt_if.busy_o         = (r_state != ST_IDLE);
    assign rt_if.src_err_o      = r_src_err;

endmodule

// File: tb/tb_column_l1route_seq.sv
// Bench for column_l1route_seq: directed spec scenarios followed by random bursts, checked against a cycle-indexed event model.
module tb_column_l1route_seq;

    localparam int L     = 2;
    localparam int BW    = 4;
    localparam int CW    = 5;
    localparam int NCYC  = 2000;
    localparam int MAXC  = NCYC + 16;
    localparam int INF   = 1 << 30;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    column_l1route_seq_if #(.BITWIDTH_SHIFT_FACTOR(BW), .COL_ADDR_WIDTH(CW)) rt ();

    column_l1route_seq #(
        .STRIDE_UNIT_SIZE (15),
        .QSN_LAT          (L),
        .COL_ADDR_WIDTH   (CW)
    ) dut (
        .sys_clk (clk),
        .rstn    (rstn),
        .rt_if   (rt)
    );

    typedef struct {
        bit          vld;
        bit          src;
        logic [BW-1:0] shift;
        logic [CW-1:0] col;
        bit          last;
    } req_t;

    req_t stim_q[$];
    req_t pend;
    bit   have_pend;

    // Expected events, indexed by the cycle at which they must be visible.
    bit            e_launch [MAXC];
    logic [BW-1:0] e_shift  [MAXC];
    bit            e_swsrc  [MAXC];
    bit            e_ov     [MAXC];
    logic [CW-1:0] e_col    [MAXC];
    bit            e_osrc   [MAXC];
    bit            e_last   [MAXC];

    bit            active;
    bit            burst_src;
    int            drain_end;
    int            src_err_from;
    int            shift_err_from;
    logic [BW-1:0] hold_shift;
    bit            hold_swsrc;
    bit            base_src;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int c);
        for (int k = c; k < MAXC; k++) begin
            e_launch[k] = 0; e_shift[k] = '0; e_swsrc[k] = 0;
            e_ov[k] = 0; e_col[k] = '0; e_osrc[k] = 0; e_last[k] = 0;
        end
        active         = 0;
        burst_src      = 0;
        drain_end      = -1;
        src_err_from   = INF;
        shift_err_from = INF;
        hold_shift     = '0;
        hold_swsrc     = 0;
        have_pend      = 0;
    endtask

    task automatic check_cycle(input int c);
        if (e_launch[c]) begin
            hold_shift = e_shift[c];
            hold_swsrc = e_swsrc[c];
        end
        check_eq("ready",     rt.req_ready_o,    c > drain_end);
        check_eq("busy",      rt.busy_o,         active || (c <= drain_end));
        check_eq("done",      rt.done_o,         c == drain_end);
        check_eq("launch",    rt.launch_o,       e_launch[c]);
        check_eq("shift",     rt.shift_factor_o, hold_shift);
        check_eq("sw_src",    rt.sw_in_src_o,    hold_swsrc);
        check_eq("out_valid", rt.out_valid_o,    e_ov[c]);
        if (e_ov[c]) begin
            check_eq("out_col",  rt.out_col_o,  e_col[c]);
            check_eq("out_src",  rt.out_src_o,  e_osrc[c]);
            check_eq("out_last", rt.out_last_o, e_last[c]);
        end
        check_eq("src_err",   rt.src_err_o,      c >= src_err_from);
`ifdef SHIFT_RANGE_CHK_EN
        check_eq("shift_err", rt.shift_err_o,    c >= shift_err_from);
`endif
    endtask

    function automatic req_t rand_req();
        req_t r;
        r.vld   = ($urandom_range(0, 9) < 7);
        r.src   = ($urandom_range(0, 9) == 0) ? ~base_src : base_src;
        r.shift = BW'($urandom_range(0, 15));
        r.col   = CW'($urandom_range(0, 31));
        r.last  = ($urandom_range(0, 3) == 0);
        if (r.vld && r.last) base_src = 1'($urandom_range(0, 1));
        return r;
    endfunction

    function automatic req_t mk(input bit v, input bit s, input int sh, input int col, input bit last);
        req_t r;
        r.vld = v; r.src = s; r.shift = BW'(sh); r.col = CW'(col); r.last = last;
        return r;
    endfunction

    task automatic drive_and_model(input int c);
        logic [BW-1:0] eff_shift;
        bit            src_eff;
        if (!have_pend) begin
            pend      = (stim_q.size() > 0) ? stim_q.pop_front() : rand_req();
            have_pend = 1;
        end
        rt.req_valid_i = pend.vld;
        rt.req_src_i   = pend.src;
        rt.req_shift_i = pend.shift;
        rt.req_col_i   = pend.col;
        rt.req_last_i  = pend.last;
        if (!pend.vld) begin
            have_pend = 0;
        end else if (c > drain_end) begin
`ifdef SHIFT_RANGE_CHK_EN
            eff_shift = (pend.shift > 14) ? '0 : pend.shift;
            if (pend.shift > 14 && shift_err_from == INF) shift_err_from = c + 1;
`else
            eff_shift = pend.shift;
`endif
            src_eff = active ? burst_src : pend.src;
            if (active && pend.src != burst_src && src_err_from == INF) src_err_from = c + 1;
            if (!active) burst_src = pend.src;
            e_launch[c+1]  = 1;
            e_shift[c+1]   = eff_shift;
            e_swsrc[c+1]   = src_eff;
            e_ov[c+1+L]    = 1;
            e_col[c+1+L]   = pend.col;
            e_osrc[c+1+L]  = src_eff;
            e_last[c+1+L]  = pend.last;
            if (pend.last) begin
                active    = 0;
                drain_end = c + 1 + L;
            end else begin
                active = 1;
            end
            have_pend = 0;
        end
    endtask

    initial begin
        bit did_rst;
        int rst_left;
        did_rst  = 0;
        rst_left = 0;
        base_src = 0;
        rt.req_valid_i = 0; rt.req_src_i = 0; rt.req_shift_i = '0;
        rt.req_col_i   = '0; rt.req_last_i = 0;
        model_reset(0);

        // Single beat, 4-beat burst, then a source-error burst and an out-of-range shift held through DRAIN.
        stim_q.push_back(mk(0, 0, 0, 0, 0));
        stim_q.push_back(mk(0, 0, 0, 0, 0));
        stim_q.push_back(mk(1, 0, 7, 3, 1));
        for (int i = 0; i < 4; i++) stim_q.push_back(mk(0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++) stim_q.push_back(mk(1, 1, 2 + i, i, i == 3));
        stim_q.push_back(mk(1, 0, 5, 8, 0));
        stim_q.push_back(mk(1, 1, 6, 9, 0));
        stim_q.push_back(mk(1, 0, 2, 10, 1));
        stim_q.push_back(mk(1, 0, 15, 4, 1));
        for (int i = 0; i < 3; i++) stim_q.push_back(mk(0, 0, 0, 0, 0));

        repeat (3) @(negedge clk);
        check_eq("rst_launch",    rt.launch_o,       0);
        check_eq("rst_out_valid", rt.out_valid_o,    0);
        check_eq("rst_done",      rt.done_o,         0);
        check_eq("rst_busy",      rt.busy_o,         0);
        check_eq("rst_src_err",   rt.src_err_o,      0);
        check_eq("rst_shift",     rt.shift_factor_o, 0);
        check_eq("rst_sw_src",    rt.sw_in_src_o,    0);
        rstn = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            cyc = c;
            if (!did_rst && c >= 800 && active) begin
                rstn     = 1'b0;
                did_rst  = 1;
                rst_left = 3;
                #1;
                model_reset(c);
            end else if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rstn = 1'b1;
            end
            check_cycle(c);
            if (rstn) begin
                drive_and_model(c);
            end else begin
                rt.req_valid_i = 0;
            end
        end
        check_eq("reset_hit", did_rst, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
